basic_alu_core: RTL and testbench

- Parameterised 4-operation registered ALU: signed subtract, bitwise NAND, leading-ones count and 2-to-4 one-hot decode, with a 4-bit status flag vector.
- Top-level datapath block of the ALU design; operands and opcode are sampled on the clock and the result and flags are registered.
- A separate simulation-only clock/reset generator drives s_CLK and s_RSTn: period CLOCK_PERIOD = 10, run length SIM_CLOCK_CYCLES = 100.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_comb.sv | 78 +++++++
 rtl/basic_alu_core.sv | 41 ++++
 tb/tb_basic_alu_core.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and flag-index definitions for the basic ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_SUB   = 2'b00,
        OP_NAND  = 2'b01,
        OP_LONES = 2'b10,
        OP_DEC   = 2'b11
    } alu_op_e;

    localparam int FLAG_ERR      = 0;
    localparam int FLAG_NEG      = 1;
    localparam int FLAG_POS      = 2;
    localparam int FLAG_OVERFLOW = 3;

    localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU stage: next result and status flags from operands and opcode.
module alu_comb #(
    parameter int WIDTH = 4,
    parameter int LEN   = 4
) (
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    input  logic [1:0]       i_oper,
    output logic [WIDTH-1:0] o_result_nxt,
    output logic [3:0]       o_flag_nxt
);
    import alu_pkg::*;

    logic [WIDTH-1:0] diff;
    logic             sub_ovf;
    logic [WIDTH-1:0] lones;
    logic             lones_run;
    logic [WIDTH-1:0] dec;
    logic             dec_err;
    logic [WIDTH-1:0] res;
    logic             err;
    logic             ovf;

    assign diff    = i_arg0 - i_arg1;
    assign sub_ovf = (i_arg0[WIDTH-1] != i_arg1[WIDTH-1]) &&
                     (diff[WIDTH-1] != i_arg0[WIDTH-1]);

    // Count stops at the first zero found scanning down from the MSB.
    always_comb begin
        lones     = '0;
        lones_run = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            if (lones_run && i_arg0[WIDTH-1-i]) begin
                lones = lones + WIDTH'(1);
            end else begin
                lones_run = 1'b0;
            end
        end
    end

    assign dec_err = |i_arg0[WIDTH-1:2];

    always_comb begin
        dec = '0;
        if (!dec_err) begin
            dec[i_arg0[1:0]] = 1'b1;
        end
    end

    always_comb begin
        res = '0;
        err = 1'b0;
        ovf = 1'b0;
        case (i_oper)
            OP_SUB: begin
                res = diff;
                ovf = sub_ovf;
            end
            OP_NAND:  res = ~(i_arg0 & i_arg1);
            OP_LONES: res = lones;
            OP_DEC: begin
                res = dec;
                err = dec_err;
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        o_result_nxt                = res;
        o_flag_nxt                  = '0;
        o_flag_nxt[FLAG_ERR]        = err;
        o_flag_nxt[FLAG_NEG]        = res[WIDTH-1];
        o_flag_nxt[FLAG_POS]        = (|res) && !res[WIDTH-1];
        o_flag_nxt[FLAG_OVERFLOW]   = ovf;
    end

endmodule

// File: rtl/basic_alu_core.sv
// Registered 4-operation ALU: combinational stage followed by result/flag register.
module basic_alu_core #(
    parameter int WIDTH = 4,
    parameter int LEN   = 4
) (
    input  logic             s_CLK,
    input  logic             s_RSTn,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    input  logic [1:0]       i_oper,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flag
);
    import alu_pkg::*;

    logic [WIDTH-1:0] result_nxt;
    logic [3:0]       flag_nxt;

    alu_comb #(
        .WIDTH (WIDTH),
        .LEN   (LEN)
    ) u_alu_comb (
        .i_arg0       (i_arg0),
        .i_arg1       (i_arg1),
        .i_oper       (i_oper),
        .o_result_nxt (result_nxt),
        .o_flag_nxt   (flag_nxt)
    );

    // s_RSTn is active-high despite its name.
    always_ff @(posedge s_CLK or posedge s_RSTn) begin
        if (s_RSTn) begin
            o_result <= '0;
            o_flag   <= '0;
        end else begin
            o_result <= result_nxt;
            o_flag   <= flag_nxt;
        end
    end

endmodule

// File: tb/tb_basic_alu_core.sv
// Self-checking bench for basic_alu_core: directed vector table, reset sequences, random vs model.
module tb_basic_alu_core;
    import alu_pkg::*;

    localparam int WIDTH            = 4;
    localparam int LEN              = 4;
    localparam int CLOCK_PERIOD     = 10;
    localparam int SIM_CLOCK_CYCLES = 100;

    logic             s_CLK;
    logic             s_RSTn;
    logic [WIDTH-1:0] i_arg0;
    logic [WIDTH-1:0] i_arg1;
    logic [1:0]       i_oper;
    logic [WIDTH-1:0] o_result;
    logic [3:0]       o_flag;

    int n_checks = 0;
    int n_pass   = 0;

    basic_alu_core #(.WIDTH(WIDTH), .LEN(LEN)) dut (
        .s_CLK    (s_CLK),
        .s_RSTn   (s_RSTn),
        .i_arg0   (i_arg0),
        .i_arg1   (i_arg1),
        .i_oper   (i_oper),
        .o_result (o_result),
        .o_flag   (o_flag)
    );

    initial begin
        s_CLK = 1'b0;
        forever #(CLOCK_PERIOD/2) s_CLK = ~s_CLK;
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
        logic [WIDTH-1:0] exp_res;
        logic [3:0]       exp_flag;
        string            name;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input logic [WIDTH-1:0] er, input logic [3:0] ef, input string name);
        n_checks++;
        if (o_result === er && o_flag === ef) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got result=%b flag=%b, want result=%b flag=%b",
                     name, o_result, o_flag, er, ef);
        end
    endtask

    // Reference model from the arithmetic rules, using wide signed integers.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [1:0] op,
                                  output logic [WIDTH-1:0] r, output logic [3:0] f);
        int d;
        int n;
        f = 4'b0000;
        r = '0;
        case (op)
            2'b00: begin
                d = int'($signed(a)) - int'($signed(b));
                r = WIDTH'(d);
                if (d > (2**(WIDTH-1)) - 1 || d < -(2**(WIDTH-1))) f[3] = 1'b1;
            end
            2'b01: r = ~(a & b);
            2'b10: begin
                n = 0;
                while (n < LEN && a[WIDTH-1-n]) n++;
                r = WIDTH'(n);
            end
            default: begin
                if ((a >> 2) != 0) begin
                    r    = '0;
                    f[0] = 1'b1;
                end else begin
                    r = WIDTH'(1 << a[1:0]);
                end
            end
        endcase
        f[1] = r[WIDTH-1];
        f[2] = (r != 0) && !r[WIDTH-1];
    endfunction

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
        i_arg0 = a;
        i_arg1 = b;
        i_oper = op;
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb, er;
        logic [1:0]       rop;
        logic [3:0]       ef;

        vecs[0]  = '{4'b0101, 4'b0011, 2'b00, 4'b0010, 4'b0100, "sub_basic"};
        vecs[1]  = '{4'b1111, 4'b0000, 2'b01, 4'b1111, 4'b0010, "nand_neg"};
        vecs[2]  = '{4'b1100, 4'b1010, 2'b10, 4'b0010, 4'b0100, "lones_1100"};
        vecs[3]  = '{4'b1111, 4'b0000, 2'b10, 4'b0100, 4'b0100, "lones_1111"};
        vecs[4]  = '{4'b0111, 4'b1111, 2'b10, 4'b0000, 4'b0000, "lones_0111"};
        vecs[5]  = '{4'b0010, 4'b1001, 2'b11, 4'b0100, 4'b0100, "dec_0010"};
        vecs[6]  = '{4'b0011, 4'b0000, 2'b11, 4'b1000, 4'b0010, "dec_0011"};
        vecs[7]  = '{4'b0110, 4'b0000, 2'b11, 4'b0000, 4'b0001, "dec_err"};
        vecs[8]  = '{4'b0111, 4'b1000, 2'b00, 4'b1111, 4'b1010, "sub_ovf_neg"};
        vecs[9]  = '{4'b1000, 4'b0001, 2'b00, 4'b0111, 4'b1100, "sub_ovf_pos"};
        vecs[10] = '{4'b0011, 4'b0011, 2'b00, 4'b0000, 4'b0000, "sub_zero"};

        s_RSTn = 1'b1;
        drive(WIDTH'($urandom()), WIDTH'($urandom()), 2'($urandom()));
        for (int i = 0; i < 2; i++) begin
            @(posedge s_CLK);
            #1;
            check('0, 4'b0000, "reset_hold");
            @(negedge s_CLK);
            drive(WIDTH'($urandom()), WIDTH'($urandom()), 2'($urandom()));
        end
        s_RSTn = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            @(posedge s_CLK);
            #1;
            check(vecs[i].exp_res, vecs[i].exp_flag, vecs[i].name);
            @(negedge s_CLK);
        end

        // Outputs must hold between edges with no new edge.
        #2;
        check(4'b0000, 4'b0000, "hold_between_edges");

        // Reset raised mid-cycle discards the operation in flight.
        drive(4'b1111, 4'b0000, 2'b01);
        @(posedge s_CLK);
        #1;
        check(4'b1111, 4'b0010, "pre_rst_nand");
        @(negedge s_CLK);
        drive(4'b0111, 4'b1000, 2'b00);
        #2;
        s_RSTn = 1'b1;
        #1;
        check('0, 4'b0000, "rst_async_clear");
        @(posedge s_CLK);
        #1;
        check('0, 4'b0000, "rst_inflight_dropped");
        @(negedge s_CLK);
        s_RSTn = 1'b0;
        drive(4'b0101, 4'b0011, 2'b00);
        @(posedge s_CLK);
        #1;
        check(4'b0010, 4'b0100, "first_after_release");

        for (int c = 0; c < 50; c++) begin
            @(negedge s_CLK);
            if (c == 25) begin
                #2;
                s_RSTn = 1'b1;
                #1;
                check('0, 4'b0000, "rand_rst_async");
                @(posedge s_CLK);
                #1;
                check('0, 4'b0000, "rand_rst_hold");
                @(negedge s_CLK);
                s_RSTn = 1'b0;
            end
            ra  = WIDTH'($urandom());
            rb  = WIDTH'($urandom());
            rop = 2'($urandom());
            if (c % 8 == 3) ra = WIDTH'($urandom_range(3));
            drive(ra, rb, rop);
            model(ra, rb, rop, er, ef);
            @(posedge s_CLK);
            #1;
            check(er, ef, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(CLOCK_PERIOD * SIM_CLOCK_CYCLES * 4);
        $display("FAIL timeout: got no finish, want finish within %0d cycles", SIM_CLOCK_CYCLES * 4);
        $fatal(1, "timeout");
    end

endmodule
